// File: rtl/csrng_pkg.sv
// Shared CSRNG application-port types plus the arbiter state encoding.
// Consumed by csrng_app_arb and csrng_app_arb_rr.
package csrng_pkg;

  typedef enum logic [3:0] {
    INV = 4'h0,
    INS = 4'h1,
    RES = 4'h2,
    GEN = 4'h3,
    UPD = 4'h4,
    UNI = 4'h5
  } acmd_e;

  typedef enum logic [2:0] {
    CMD_STS_SUCCESS      = 3'h0,
    CMD_STS_INVALID_ACMD = 3'h1,
    CMD_STS_INVALID_GEN  = 3'h2,
    CMD_STS_INVALID_SEQ  = 3'h3
  } csrng_cmd_sts_e;

  typedef struct packed {
    logic        csrng_req_valid;
    logic [31:0] csrng_req_bus;
    logic        genbits_ready;
  } csrng_req_t;

  typedef struct packed {
    logic           csrng_req_ready;
    logic           csrng_rsp_ack;
    csrng_cmd_sts_e csrng_rsp_sts;
    logic           genbits_valid;
    logic           genbits_fips;
    logic [127:0]   genbits_bus;
  } csrng_rsp_t;

  typedef struct packed {
    logic [19:0] glen;
    logic [3:0]  flags;
    logic [3:0]  clen;
    acmd_e       acmd;
  } csrng_cmd_t;

  localparam int ArbSmStateWidth = 6;

  // Pairwise Hamming distance >= 3 so a single upset cannot land on another legal state.
  typedef enum logic [ArbSmStateWidth-1:0] {
    ArbIdle  = 6'b011001,
    ArbCmd   = 6'b100011,
    ArbWait  = 6'b110110,
    ArbError = 6'b001110
  } arb_sm_state_e;

  function automatic logic [3:0] cmd_clen(input logic [31:0] bus);
    csrng_cmd_t hdr;
    hdr = csrng_cmd_t'(bus);
    return hdr.clen;
  endfunction

endpackage

// File: rtl/csrng_app_arb_rr.sv
// Combinational round-robin picker: searches from last_grant+1 upward with wrap,
// so last_grant itself has the lowest priority.
module csrng_app_arb_rr
  import csrng_pkg::*;
#(
  parameter int NumApps = 3,
  localparam int IdxW = $clog2(NumApps)
) (
  input  logic [NumApps-1:0] req,
  input  logic [IdxW-1:0]    last_grant,
  output logic [IdxW-1:0]    winner,
  output logic               any
);

  always_comb begin
    logic [IdxW-1:0] cand;
    cand   = '0;
    winner = '0;
    any    = 1'b0;
    // Walk from lowest to highest priority so the last hit is the winner.
    for (int i = NumApps; i >= 1; i--) begin
      cand = IdxW'((32'(last_grant) + 32'(i)) % 32'(NumApps));
      if (req[cand]) begin
        winner = cand;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/csrng_app_arb.sv
// Round-robin arbiter sharing one CSRNG application port among NumApps requesters.
// Optional wait-phase watchdog enabled by defining CSRNG_APP_ARB_TIMEOUT_EN.
module csrng_app_arb
  import csrng_pkg::*;
#(
  parameter int NumApps       = 3,
  parameter int TimeoutCycles = 4096,
  localparam int IdxW = $clog2(NumApps)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  csrng_req_t      app_req_i [NumApps],
  output csrng_rsp_t      app_rsp_o [NumApps],
  output csrng_req_t      csrng_req_o,
  input  csrng_rsp_t      csrng_rsp_i,
  output logic [IdxW-1:0] grant_idx_o,
  output logic            busy_o,
  output logic            fsm_err_o,
  output logic            timeout_err_o
);

  arb_sm_state_e     r_state;
  logic [IdxW-1:0]   r_grant_idx;
  logic [IdxW-1:0]   r_last_grant;
  logic [3:0]        r_word_cnt;
  logic              r_hdr_done;

  logic [NumApps-1:0] w_req_valid;
  logic [IdxW-1:0]    w_winner;
  logic               w_any;
  csrng_req_t         w_sel;
  logic               w_acc;
  logic [3:0]         w_clen;
  logic               w_timeout;

  always_comb begin
    w_req_valid = '0;
    for (int i = 0; i < NumApps; i++) w_req_valid[i] = app_req_i[i].csrng_req_valid;
  end

  csrng_app_arb_rr #(.NumApps(NumApps)) u_rr (
    .req        (w_req_valid),
    .last_grant (r_last_grant),
    .winner     (w_winner),
    .any        (w_any)
  );

  assign w_sel  = app_req_i[r_grant_idx];
  assign w_acc  = (r_state == ArbCmd) && w_sel.csrng_req_valid && csrng_rsp_i.csrng_req_ready;
  assign w_clen = cmd_clen(w_sel.csrng_req_bus);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ArbIdle;
      r_grant_idx  <= '0;
      r_last_grant <= IdxW'(NumApps - 1);
      r_word_cnt   <= '0;
      r_hdr_done   <= 1'b0;
    end else begin
      case (r_state)
        ArbIdle: begin
          r_hdr_done <= 1'b0;
          r_word_cnt <= '0;
          if (w_any) begin
            r_grant_idx <= w_winner;
            r_state     <= ArbCmd;
          end
        end
        ArbCmd: begin
          if (w_acc) begin
            if (!r_hdr_done) begin
              r_hdr_done <= 1'b1;
              r_word_cnt <= w_clen;
              if (w_clen == 4'd0) r_state <= ArbWait;
            end else begin
              r_word_cnt <= r_word_cnt - 4'd1;
              if (r_word_cnt == 4'd1) r_state <= ArbWait;
            end
          end
        end
        ArbWait: begin
          if (csrng_rsp_i.csrng_rsp_ack) begin
            r_last_grant <= r_grant_idx;
            r_state      <= ArbIdle;
          end else if (w_timeout) begin
            r_state <= ArbError;
          end
        end
        ArbError: r_state <= ArbError;
        default:  r_state <= ArbError;
      endcase
    end
  end

`ifdef CSRNG_APP_ARB_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_timeout_err;
  logic        w_gb_hs;

  assign w_gb_hs   = (r_state == ArbWait) && csrng_rsp_i.genbits_valid && w_sel.genbits_ready;
  assign w_timeout = (r_state == ArbWait) && !csrng_rsp_i.csrng_rsp_ack && !w_gb_hs &&
                     (r_to_cnt == 16'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      // Leaving ArbWait always clears, so every entry starts from zero.
      if ((r_state != ArbWait) || w_gb_hs || csrng_rsp_i.csrng_rsp_ack) r_to_cnt <= '0;
      else                                                              r_to_cnt <= r_to_cnt + 16'd1;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err_o = r_timeout_err;
`else
  assign w_timeout     = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  always_comb begin
    csrng_req_o = '0;
    for (int i = 0; i < NumApps; i++) app_rsp_o[i] = '0;
    case (r_state)
      ArbCmd: begin
        csrng_req_o.csrng_req_valid = w_sel.csrng_req_valid;
        csrng_req_o.csrng_req_bus   = w_sel.csrng_req_bus;
        app_rsp_o[r_grant_idx].csrng_req_ready = csrng_rsp_i.csrng_req_ready;
      end
      ArbWait: begin
        csrng_req_o.genbits_ready = w_sel.genbits_ready;
        app_rsp_o[r_grant_idx].csrng_rsp_ack = csrng_rsp_i.csrng_rsp_ack;
        app_rsp_o[r_grant_idx].csrng_rsp_sts = csrng_rsp_i.csrng_rsp_sts;
        app_rsp_o[r_grant_idx].genbits_valid = csrng_rsp_i.genbits_valid;
        app_rsp_o[r_grant_idx].genbits_fips  = csrng_rsp_i.genbits_fips;
        app_rsp_o[r_grant_idx].genbits_bus   = csrng_rsp_i.genbits_bus;
      end
      default: ;
    endcase
  end

  assign grant_idx_o = r_grant_idx;
  assign busy_o      = (r_state != ArbIdle);
  assign fsm_err_o   = !(r_state inside {ArbIdle, ArbCmd, ArbWait});

endmodule

// File: doc/csrng_app_arb.md
# csrng_app_arb

Shares the single CSRNG application command interface among `NumApps` requesters (e.g. entropy consumers, key manager, software port). It sits directly in front of the CSRNG command/genbits port. The block grants one requester at a time by round-robin. It forwards that requester's complete command (header plus `clen` additional-data words), then holds the grant while routing genbits and the response back, until `csrng_rsp_ack`.

## Interface
- `NumApps`, default 3: number of requesters, 2..8.
- `TimeoutCycles`, default 4096: watchdog limit in the wait phase. Used only under `CSRNG_APP_ARB_TIMEOUT_EN`.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset. One clock; reset is asynchronous and active-low.
- `app_req_i`  in  `NumApps` x `csrng_req_t` (34 b each): requester command/genbits-ready.
- `app_rsp_o`  out  `NumApps` x `csrng_rsp_t` (135 b each): per-requester ready/ack/status/genbits.
- `csrng_req_o`  out  `csrng_req_t`: to the CSRNG application port.
- `csrng_rsp_i`  in  `csrng_rsp_t`: from the CSRNG application port.
- `grant_idx_o`  out  `$clog2(NumApps)`: current grant index. Reset value 0.
- `busy_o`  out  1: high whenever the state is not ArbIdle. Reset value 0.
- `fsm_err_o`  out  1: sticky; high when the state register holds an illegal value. Reset value 0.
- `timeout_err_o`  out  1: sticky watchdog error. Reset value 0.

## Operation
- States, 6-bit sparse encoding with minimum Hamming distance 3:
  - ArbIdle = 6'b011001
  - ArbCmd = 6'b100011
  - ArbWait = 6'b110110
  - ArbError = 6'b001110
- Any other state value goes to ArbError. ArbError is terminal until reset. It asserts `fsm_err_o`, and also `timeout_err_o` if entered by timeout.
- ArbIdle:
  - All outputs are idle. `csrng_req_o` = '0.
  - If any `app_req_i[i].csrng_req_valid` is high, pick a winner by round-robin starting at `last_grant+1` (wrapping), register it into `grant_idx`, and go to ArbCmd.
- ArbCmd:
  - `csrng_req_o.csrng_req_valid`/`csrng_req_bus` = `app_req_i[g]`.
  - `app_rsp_o[g].csrng_req_ready` = `csrng_rsp_i.csrng_req_ready`.
  - On the first accepted word (valid & ready), decode the header `csrng_cmd_t`: load `word_cnt` = `clen` (4 b).
  - If `clen`=0, go to ArbWait. Otherwise each further accepted word decrements `word_cnt`; the transfer at `word_cnt`=1 goes to ArbWait.
- ArbWait:
  - `csrng_req_o.csrng_req_valid` = 0. `genbits_ready` = `app_req_i[g].genbits_ready`.
  - `app_rsp_o[g]` mirrors `csrng_rsp_i` for `csrng_rsp_ack`, `csrng_rsp_sts`, `genbits_valid`, `genbits_fips` and `genbits_bus`.
  - On `csrng_rsp_ack`: `last_grant` ← `g`, go to ArbIdle.
- Non-granted requesters, and all requesters outside ArbCmd/ArbWait, see every `app_rsp_o` field as 0:
  - `csrng_rsp_sts` = `CMD_STS_SUCCESS`; the undriven 'z value is never output.
  - `csrng_req_ready` = 0.
- `genbits_ready` to CSRNG is 0 outside ArbWait.
- A requester dropping valid mid-command is not supported. The block keeps the grant and waits.
- Simultaneous requests: exactly one grant, by round-robin. `last_grant` resets to `NumApps-1`, so app 0 wins the first contention.
- Reset mid-operation: immediate return to ArbIdle, counters cleared, grant dropped. The downstream must be reset in the same domain.

## Timing
- Request valid in cycle N (ArbIdle) → grant registered, ArbCmd at N+1. The first header transfer is possible at N+1.
- Ready and genbits paths are combinational pass-throughs through a `grant_idx`-indexed mux; no added latency once granted.
- Ack in cycle M → ArbIdle at M+1 → earliest next grant at M+2.
- A full command of 1+`clen` words takes at least 1+`clen` cycles in ArbCmd.

## Configuration
- `CSRNG_APP_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter runs in ArbWait. It clears on each genbits handshake or ack, and on entry to ArbWait.
  - Reaching `TimeoutCycles` → ArbError, with `timeout_err_o`=1.
- Not defined: no counter; `timeout_err_o` is tied 0 and `TimeoutCycles` is ignored.

## Structure
- `csrng_pkg` gains `arb_sm_state_e` (the encodings above) and `ArbSmStateWidth` = 6. It already provides `csrng_req_t`, `csrng_rsp_t`, `csrng_cmd_t` and `csrng_cmd_sts_e`.
- One sub-module: `csrng_app_arb_rr`, a round-robin picker with ports `req[NumApps]`, `last_grant` → `winner`, `any`. It is purely combinational.

## Test plan
- Single request: app1 sends INS with `clen`=2 (3 words). Expect:
  - `grant_idx_o`=1, 3 words forwarded in order, then ArbWait.
  - Ack with sts 0 appears only on `app_rsp_o[1]`.
  - `busy_o` falls 1 cycle after ack.
- Contention: apps 0, 1 and 2 all assert valid at once, from reset. Expect grant order 0,1,2, then 0 again on re-request.
- GEN with `glen`=3: 3 genbits beats routed only to the granted app. Downstream `genbits_ready` follows that app's ready; a stall of 5 cycles is honoured.
- `clen`=0 command: exactly 1 word forwarded, then ArbWait. Other apps' `csrng_req_ready` stay 0 throughout.
- Reset asserted in ArbCmd after 1 of 3 words: all outputs zero immediately, `busy_o`=0, next grant goes to app 0.
- With `CSRNG_APP_ARB_TIMEOUT_EN` and `TimeoutCycles`=16: no ack for 16 cycles → `timeout_err_o`=1 and `fsm_err_o`=1, sticky until reset. Forcing the state register to 6'b000000 → `fsm_err_o`=1.
